// File: rtl/fmul_arbiter.sv
// Two-requester arbiter in front of one shared single-precision multiplier,
// with a two-stage pipeline: S1 holds operands, S2 holds the product.

// Combinational IEEE-754 single multiply with round-to-nearest-even.
// Denormal inputs and underflowing results are flushed to signed zero.
module fmul (
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic [31:0] y,
  output logic        ovf
);
  logic        sign;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic        norm_hi, rnd;
  logic [47:0] prod;
  logic [22:0] mant;
  logic [23:0] mant_r;
  logic [10:0] exp_n;

  always_comb begin
    sign   = x1[31] ^ x2[31];
    a_nan  = (x1[30:23] == 8'hFF) && (x1[22:0] != 23'd0);
    b_nan  = (x2[30:23] == 8'hFF) && (x2[22:0] != 23'd0);
    a_inf  = (x1[30:23] == 8'hFF) && (x1[22:0] == 23'd0);
    b_inf  = (x2[30:23] == 8'hFF) && (x2[22:0] == 23'd0);
    a_zero = (x1[30:23] == 8'h00);
    b_zero = (x2[30:23] == 8'h00);
    prod   = {1'b1, x1[22:0]} * {1'b1, x2[22:0]};
    norm_hi = prod[47];
    if (norm_hi) begin
      mant = prod[46:24];
      rnd  = prod[23] & ((|prod[22:0]) | prod[24]);
    end else begin
      mant = prod[45:23];
      rnd  = prod[22] & ((|prod[21:0]) | prod[23]);
    end
    mant_r = {1'b0, mant} + {23'd0, rnd};
    // Exponent kept in 11 bits so it can be read as signed for range checks.
    exp_n  = {3'b000, x1[30:23]} + {3'b000, x2[30:23]} - 11'd127
           + {10'd0, norm_hi} + {10'd0, mant_r[23]};
    y   = 32'd0;
    ovf = 1'b0;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      y = 32'h7FC0_0000;
    end else if (a_inf || b_inf) begin
      y = {sign, 8'hFF, 23'd0};
    end else if (a_zero || b_zero) begin
      y = {sign, 31'd0};
    end else if ($signed(exp_n) >= 11'sd255) begin
      y   = {sign, 8'hFF, 23'd0};
      ovf = 1'b1;
    end else if ($signed(exp_n) <= 11'sd0) begin
      y = {sign, 31'd0};
    end else begin
      y = {sign, exp_n[7:0], mant_r[22:0]};
    end
  end
endmodule

module fmul_arbiter #(
  parameter bit RR = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_x1,
  input  logic [31:0] req0_x2,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_x1,
  input  logic [31:0] req1_x2,
  output logic        resp0_valid,
  input  logic        resp0_ready,
  output logic [31:0] resp0_y,
  output logic        resp0_ovf,
  output logic        resp1_valid,
  input  logic        resp1_ready,
  output logic [31:0] resp1_y,
  output logic        resp1_ovf,
  output logic        busy
);
  logic        s1_valid_q, s1_valid_d;
  logic        s1_tag_q, s1_tag_d;
  logic [31:0] s1_x1_q, s1_x1_d;
  logic [31:0] s1_x2_q, s1_x2_d;
  logic        s2_valid_q, s2_valid_d;
  logic        s2_tag_q, s2_tag_d;
  logic [31:0] s2_y_q, s2_y_d;
  logic        s2_ovf_q, s2_ovf_d;
  logic        ptr_q, ptr_d;

  logic        adv1, adv2, gnt_valid, gnt_idx;
  logic [31:0] mul_y;
  logic        mul_ovf;

  fmul u_fmul (
    .x1  (s1_x1_q),
    .x2  (s1_x2_q),
    .y   (mul_y),
    .ovf (mul_ovf)
  );

  always_comb begin
    adv2 = !s2_valid_q || (s2_tag_q ? resp1_ready : resp0_ready);
    adv1 = !s1_valid_q || adv2;
    if (req0_valid && req1_valid) begin
      gnt_idx = RR ? ptr_q : 1'b0;
    end else begin
      gnt_idx = req1_valid;
    end
    gnt_valid  = (req0_valid || req1_valid) && adv1 && !rst;
    req0_ready = gnt_valid && !gnt_idx;
    req1_ready = gnt_valid && gnt_idx;
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_tag_d   = s1_tag_q;
    s1_x1_d    = s1_x1_q;
    s1_x2_d    = s1_x2_q;
    s2_valid_d = s2_valid_q;
    s2_tag_d   = s2_tag_q;
    s2_y_d     = s2_y_q;
    s2_ovf_d   = s2_ovf_q;
    ptr_d      = ptr_q;
    if (adv2) begin
      s2_valid_d = s1_valid_q;
      s2_tag_d   = s1_tag_q;
      if (s1_valid_q) begin
        s2_y_d   = mul_y;
        s2_ovf_d = mul_ovf;
      end
    end
    if (adv1) begin
      s1_valid_d = gnt_valid;
      if (gnt_valid) begin
        s1_tag_d = gnt_idx;
        s1_x1_d  = gnt_idx ? req1_x1 : req0_x1;
        s1_x2_d  = gnt_idx ? req1_x2 : req0_x2;
      end
    end
    // The pointer hands priority to whoever lost this grant.
    if (gnt_valid && RR) begin
      ptr_d = ~gnt_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_tag_q   <= 1'b0;
      s1_x1_q    <= 32'd0;
      s1_x2_q    <= 32'd0;
      s2_valid_q <= 1'b0;
      s2_tag_q   <= 1'b0;
      s2_y_q     <= 32'd0;
      s2_ovf_q   <= 1'b0;
      ptr_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_tag_q   <= s1_tag_d;
      s1_x1_q    <= s1_x1_d;
      s1_x2_q    <= s1_x2_d;
      s2_valid_q <= s2_valid_d;
      s2_tag_q   <= s2_tag_d;
      s2_y_q     <= s2_y_d;
      s2_ovf_q   <= s2_ovf_d;
      ptr_q      <= ptr_d;
    end
  end

  assign resp0_valid = s2_valid_q && !s2_tag_q;
  assign resp1_valid = s2_valid_q && s2_tag_q;
  assign resp0_y     = s2_y_q;
  assign resp1_y     = s2_y_q;
  assign resp0_ovf   = s2_ovf_q;
  assign resp1_ovf   = s2_ovf_q;
  assign busy        = s1_valid_q || s2_valid_q;
endmodule

// File: tb/tb_fmul_arbiter.sv
// Scoreboard bench for fmul_arbiter: expectations are queued when a request is
// driven/accepted and compared when the matching response handshake occurs.
module tb_fmul_arbiter;
  logic        clk, rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_x1, req0_x2, req1_x1, req1_x2;
  logic        resp0_valid, resp0_ready, resp0_ovf;
  logic        resp1_valid, resp1_ready, resp1_ovf;
  logic [31:0] resp0_y, resp1_y;
  logic        busy;

  logic        fp_req0_valid, fp_req0_ready, fp_req1_valid, fp_req1_ready;
  logic        fp_resp0_valid, fp_resp1_valid, fp_resp0_ovf, fp_resp1_ovf;
  logic [31:0] fp_resp0_y, fp_resp1_y;
  logic        fp_busy, fp_resp_ready;

  typedef struct {
    logic [31:0] y;
    logic        ovf;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t exp_q0[$];
  exp_t exp_q1[$];
  int   order_q[$];
  int   grant_log[$];
  int   resp_cycles[$];
  exp_t cur0, cur1;
  bit   lat_on, watch_busy;
  int   idle_busy, cyc;
  int   n_checks, n_errors;

  fmul_arbiter #(.RR(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x1(req0_x1), .req0_x2(req0_x2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x1(req1_x1), .req1_x2(req1_x2),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_y(resp0_y), .resp0_ovf(resp0_ovf),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_y(resp1_y), .resp1_ovf(resp1_ovf),
    .busy(busy)
  );

  fmul_arbiter #(.RR(1'b0)) dut_fp (
    .clk(clk), .rst(rst),
    .req0_valid(fp_req0_valid), .req0_ready(fp_req0_ready), .req0_x1(req0_x1), .req0_x2(req0_x2),
    .req1_valid(fp_req1_valid), .req1_ready(fp_req1_ready), .req1_x1(req1_x1), .req1_x2(req1_x2),
    .resp0_valid(fp_resp0_valid), .resp0_ready(fp_resp_ready), .resp0_y(fp_resp0_y), .resp0_ovf(fp_resp0_ovf),
    .resp1_valid(fp_resp1_valid), .resp1_ready(fp_resp_ready), .resp1_y(fp_resp1_y), .resp1_ovf(fp_resp1_ovf),
    .busy(fp_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  // Exact float encoding of a positive integer below 2^24.
  function automatic logic [31:0] int2f(input int n);
    int p;
    logic [31:0] m;
    logic [7:0]  e;
    if (n == 0) return 32'd0;
    p = 0;
    for (int i = 0; i < 24; i++) if (n >= (1 << i)) p = i;
    m = (32'(n) << (23 - p)) & 32'h007F_FFFF;
    e = 8'(127 + p);
    return {1'b0, e, m[22:0]};
  endfunction

  task automatic check_resp(input int t, input logic [31:0] y, input logic ovf);
    exp_t e;
    int   front;
    checkOutput($sformatf("resp%0d_pending", t), (t == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0), 1);
    front = (order_q.size() > 0) ? order_q[0] : -1;
    checkOutput($sformatf("resp%0d_order", t), front, t);
    if (order_q.size() > 0) void'(order_q.pop_front());
    if ((t == 0 && exp_q0.size() > 0) || (t == 1 && exp_q1.size() > 0)) begin
      e = (t == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      checkOutput($sformatf("resp%0d_y", t), y, e.y);
      checkOutput($sformatf("resp%0d_ovf", t), ovf, e.ovf);
      if (e.lat) checkOutput($sformatf("resp%0d_latency", t), cyc - e.cyc, 2);
    end
    resp_cycles.push_back(cyc);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (req0_valid && req0_ready) begin
        e = cur0; e.cyc = cyc; e.lat = lat_on;
        exp_q0.push_back(e); order_q.push_back(0); grant_log.push_back(0);
      end
      if (req1_valid && req1_ready) begin
        e = cur1; e.cyc = cyc; e.lat = lat_on;
        exp_q1.push_back(e); order_q.push_back(1); grant_log.push_back(1);
      end
      if (resp0_valid && resp0_ready) check_resp(0, resp0_y, resp0_ovf);
      if (resp1_valid && resp1_ready) check_resp(1, resp1_y, resp1_ovf);
      if (watch_busy && !busy) idle_busy++;
    end
  end

  task automatic applyStimulus(input int t, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] y, input logic ovf);
    bit got;
    if (t == 0) begin
      req0_x1 = a; req0_x2 = b; cur0.y = y; cur0.ovf = ovf; req0_valid = 1'b1;
    end else begin
      req1_x1 = a; req1_x2 = b; cur1.y = y; cur1.ovf = ovf; req1_valid = 1'b1;
    end
    got = 1'b0;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      got = (t == 0) ? req0_ready : req1_ready;
      @(posedge clk); #1;
    end
    if (t == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    checkOutput($sformatf("accepted_req%0d", t), got, 1);
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 50; n++) begin
      if (exp_q0.size() == 0 && exp_q1.size() == 0) break;
      @(posedge clk); #1;
    end
    checkOutput("drain_left", exp_q0.size() + exp_q1.size(), 0);
  endtask

  initial begin
    logic [31:0] y_hold;
    int a, b, t, n0, n1, fp_r0, fp_r1;
    n_checks = 0; n_errors = 0; cyc = 0; lat_on = 1'b1; watch_busy = 1'b0; idle_busy = 0;
    rst = 1'b1; req0_valid = 0; req1_valid = 0; req0_x1 = 0; req0_x2 = 0; req1_x1 = 0; req1_x2 = 0;
    resp0_ready = 1'b1; resp1_ready = 1'b1; fp_req0_valid = 0; fp_req1_valid = 0; fp_resp_ready = 1'b1;
    cur0 = '{32'd0, 1'b0, 0, 1'b0}; cur1 = cur0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("rst_req0_ready", req0_ready, 0);
    checkOutput("rst_req1_ready", req1_ready, 0);
    checkOutput("rst_resp0_valid", resp0_valid, 0);
    checkOutput("rst_resp1_valid", resp1_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_resp0_y", resp0_y, 0);
    checkOutput("rst_resp1_ovf", resp1_ovf, 0);

    $display("[TB] directed vectors");
    applyStimulus(0, 32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0);
    @(negedge clk);
    checkOutput("d1_resp0_early", resp0_valid, 0);
    @(negedge clk);
    checkOutput("d1_resp0_valid", resp0_valid, 1);
    checkOutput("d1_resp1_valid", resp1_valid, 0);
    @(posedge clk); #1;
    applyStimulus(1, 32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 1'b1);
    applyStimulus(1, 32'hBF80_0000, 32'h4020_0000, 32'hC020_0000, 1'b0);
    applyStimulus(0, 32'h0000_0000, 32'h40A0_0000, 32'h0000_0000, 1'b0);
    applyStimulus(0, 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 1'b0);
    applyStimulus(1, 32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, 1'b0);
    applyStimulus(0, 32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0002, 1'b0);
    wait_drain();

    $display("[TB] random integer products");
    for (int i = 0; i < 10; i++) begin
      a = $urandom_range(1, 4095); b = $urandom_range(1, 4095); t = $urandom_range(0, 1);
      applyStimulus(t, int2f(a), int2f(b), int2f(a * b), 1'b0);
    end
    wait_drain();

    $display("[TB] back-to-back burst");
    resp_cycles.delete();
    applyStimulus(0, int2f(2), int2f(3), int2f(6), 1'b0);
    watch_busy = 1'b1; idle_busy = 0;
    for (int i = 1; i < 6; i++) applyStimulus(0, int2f(i + 2), int2f(5), int2f((i + 2) * 5), 1'b0);
    wait_drain();
    watch_busy = 1'b0;
    checkOutput("burst_count", resp_cycles.size(), 6);
    if (resp_cycles.size() == 6) checkOutput("burst_span", resp_cycles[5] - resp_cycles[0], 5);
    checkOutput("burst_busy_gaps", idle_busy, 0);

    $display("[TB] consumer stall");
    lat_on = 1'b0; resp0_ready = 1'b0;
    applyStimulus(0, int2f(3), int2f(5), int2f(15), 1'b0);
    applyStimulus(0, int2f(7), int2f(9), int2f(63), 1'b0);
    req0_x1 = int2f(11); req0_x2 = int2f(13); cur0.y = int2f(143); cur0.ovf = 1'b0; req0_valid = 1'b1;
    @(negedge clk);
    y_hold = resp0_y;
    checkOutput("stall_first_y", y_hold, int2f(15));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stall_req0_ready", req0_ready, 0);
      checkOutput("stall_resp0_valid", resp0_valid, 1);
      checkOutput("stall_resp0_y", resp0_y, y_hold);
      checkOutput("stall_busy", busy, 1);
    end
    @(posedge clk); #1;
    resp0_ready = 1'b1;
    applyStimulus(0, int2f(11), int2f(13), int2f(143), 1'b0);
    wait_drain();

    $display("[TB] reset with full pipeline");
    resp0_ready = 1'b0;
    applyStimulus(0, int2f(4), int2f(4), int2f(16), 1'b0);
    applyStimulus(0, int2f(5), int2f(5), int2f(25), 1'b0);
    rst = 1'b1;
    req0_x1 = int2f(6); req0_x2 = int2f(7); cur0.y = int2f(42); cur0.ovf = 1'b0;
    req1_x1 = int2f(10); req1_x2 = int2f(11); cur1.y = int2f(110); cur1.ovf = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    checkOutput("inrst_req0_ready", req0_ready, 0);
    checkOutput("inrst_req1_ready", req1_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q0.delete(); exp_q1.delete(); order_q.delete(); grant_log.delete();
    checkOutput("post_rst_busy", busy, 0);
    checkOutput("post_rst_resp0_valid", resp0_valid, 0);
    checkOutput("post_rst_resp1_valid", resp1_valid, 0);
    checkOutput("post_rst_resp0_y", resp0_y, 0);
    resp0_ready = 1'b1; resp1_ready = 1'b1; lat_on = 1'b1;

    $display("[TB] round-robin contention");
    for (int n = 0; n < 20; n++) begin
      if (grant_log.size() >= 4) break;
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    checkOutput("rr_grants", grant_log.size(), 4);
    if (grant_log.size() == 4) begin
      checkOutput("rr_grant0", grant_log[0], 0);
      checkOutput("rr_grant1", grant_log[1], 1);
      checkOutput("rr_grant2", grant_log[2], 0);
      checkOutput("rr_grant3", grant_log[3], 1);
    end
    wait_drain();

    $display("[TB] fixed-priority contention");
    n0 = 0; n1 = 0; fp_r0 = 0; fp_r1 = 0;
    fp_req0_valid = 1'b1; fp_req1_valid = 1'b1;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (fp_req0_valid && fp_req0_ready) n0++;
      if (fp_req1_valid && fp_req1_ready) n1++;
      if (fp_resp0_valid) begin
        fp_r0++;
        checkOutput("fp_resp0_y", fp_resp0_y, int2f(42));
      end
      if (fp_resp1_valid) fp_r1++;
      @(posedge clk); #1;
      if (n0 + n1 >= 4) begin
        fp_req0_valid = 1'b0; fp_req1_valid = 1'b0;
      end
    end
    checkOutput("fp_req0_grants", n0, 4);
    checkOutput("fp_req1_grants", n1, 0);
    checkOutput("fp_resp0_count", fp_r0, 4);
    checkOutput("fp_resp1_count", fp_r1, 0);
    checkOutput("fp_busy_idle", fp_busy, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/fmul_arbiter.md
FMUL_ARBITER -- requirements
Module: fmul_arbiter

Interface
REQ-001 SHALL have parameter RR, default 1: 1 = round-robin arbitration, 0 = fixed priority with requester 0 highest.
REQ-002 SHALL have port clk, input, 1: sole clock, all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port req0_valid, input, 1: requester 0 operands valid.
REQ-005 SHALL have port req0_ready, output, 1: requester 0 operands accepted this cycle when high with req0_valid.
REQ-006 SHALL have port req0_x1, input, 32: requester 0 operand 1, IEEE-754 single.
REQ-007 SHALL have port req0_x2, input, 32: requester 0 operand 2, IEEE-754 single.
REQ-008 SHALL have ports req1_valid, req1_ready, req1_x1, req1_x2 with the same directions, widths and meanings for requester 1.
REQ-009 SHALL have port resp0_valid, output, 1: result for requester 0 held stable.
REQ-010 SHALL have port resp0_ready, input, 1: requester 0 takes the result this cycle.
REQ-011 SHALL have port resp0_y, output, 32: product for requester 0.
REQ-012 SHALL have port resp0_ovf, output, 1: overflow flag of that product.
REQ-013 SHALL have ports resp1_valid, resp1_ready, resp1_y, resp1_ovf, identical in form, for requester 1.
REQ-014 SHALL have port busy, output, 1: high while either pipeline stage holds an operation.

Function
REQ-015 SHALL instantiate exactly one combinational fmul (x1, x2 -> y, ovf) shared by both requesters.
REQ-016 SHALL implement a two-stage pipeline: S1 register {valid, tag, x1, x2}; S2 register {valid, tag, y, ovf}, where S2 captures the fmul outputs computed from S1.
REQ-017 SHALL advance S2 (adv2) when S2 is empty or the resp_ready selected by the S2 tag is high.
REQ-018 SHALL advance S1 (adv1) when S1 is empty or adv2 is high.
REQ-019 SHALL accept at most one request per cycle, only when adv1 is high; the accepted request loads S1 with tag = requester index.
REQ-020 SHALL assert reqN_ready combinationally only for the granted requester in a cycle where adv1 is high and reqN_valid is high; the other ready stays low.
REQ-021 SHALL grant, when RR=1 and both requesters are valid, the requester indicated by a 1-bit priority pointer; a single valid requester is granted regardless of the pointer.
REQ-022 SHALL set the pointer, when RR=1, to the non-granted index after every accepted request; with no acceptance the pointer holds.
REQ-023 SHALL always grant requester 0 over requester 1 when RR=0; the pointer is unused.
REQ-024 SHALL produce a result with latency 2: a request accepted at edge N drives respT_valid high during the cycle after edge N+1, with no stalls.
REQ-025 SHALL drive respT_valid = S2.valid AND (S2.tag == T); the respT_y and respT_ovf outputs are S2 contents and stay stable while respT_valid is high and respT_ready is low.
REQ-026 SHALL return results in acceptance order; sustained throughput is 1 result per cycle when the consumers are always ready.
REQ-027 SHALL, when S2 is stalled, hold S1 if S1 is full and deassert both req ready signals; no operand or result is dropped or duplicated.
REQ-028 SHALL, on an accept and S2 drain in the same cycle, shift S1 into S2 and load S1 with the new request in that cycle.
REQ-029 SHALL pass NaN, infinity and denormal handling through unchanged from fmul; the arbiter never modifies y or ovf.
REQ-030 SHALL drive busy = S1.valid OR S2.valid.

Reset
REQ-031 SHALL, on rst high at a rising edge, clear S1.valid, S2.valid and the pointer (pointer = 0) regardless of any in-flight operation; in-flight results are discarded.
REQ-032 SHALL hold req0_ready, req1_ready, resp0_valid, resp1_valid and busy at 0 in the cycle after reset; resp*_y = 0 and resp*_ovf = 0 at reset.
REQ-033 SHALL ignore req*_valid during any cycle in which rst is high.

Verification
REQ-034 SHALL verify: req0 only, x1=0x3FC00000, x2=0x40000000, resp0_ready=1 -> resp0_valid 2 cycles after accept, resp0_y=0x40400000, resp0_ovf=0, resp1_valid=0.
REQ-035 SHALL verify: both requesters valid for 4 cycles, RR=1, after reset -> grant order 0,1,0,1 with results tagged accordingly; with RR=0 -> requester 0 receives all 4 grants.
REQ-036 SHALL verify: req1 x1=x2=0x7F000000 -> resp1_y=0x7F800000, resp1_ovf=1.
REQ-037 SHALL verify: resp0_ready held low 5 cycles with continuous req0 traffic -> S1 and S2 fill, req0_ready=0, resp0_y stable; after release, the results emerge in order with none lost.
REQ-038 SHALL verify: rst asserted with S1 and S2 full -> next cycle busy=0, resp*_valid=0, pointer=0, and the discarded results never appear.
REQ-039 SHALL verify: back-to-back accepts with both consumers ready -> one result per cycle and busy=1 throughout the burst.
